alu_operand_sequencer: RTL

Upstream feeder for the 8-bit ALU core (alu_8bit). It loads full 8-bit operands A and B and a 3-bit opcode one byte at a time from the 8 shared input pins, using a host-driven load strobe. It then holds the operands stable for the ALU, waits a configurable settle time, and captures Result/Cout into output registers. This removes the 4-bit operand and shared-pin limits of the current top-level wrapper.

---
 rtl/alu_operand_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_operand_sequencer.sv
// ----------------------------------------------------------------------------
// alu_operand_sequencer
//
// Feeds the 8-bit ALU core from a shared 8-pin host bus. The host strobes
// load_i once per byte: operand A, operand B, then the opcode (low 3 bits).
// The operands are then held steady while the ALU settles for ALU_LATENCY
// cycles, after which Result/Cout are captured and valid_o is raised.
//
// State table:
//   state  | enc | meaning
//   S_A    | 000 | waiting for operand A byte
//   S_B    | 001 | waiting for operand B byte
//   S_OP   | 010 | waiting for opcode byte
//   S_EXEC | 011 | operands held, counting down the ALU settle time
//   S_DONE | 100 | result captured and held; next byte starts a new A
//
// Ports:
//   clk, rst_n           system clock, async active-low reset
//   data_in[7:0]         host byte, sampled on the internal load pulse
//   load_i               asynchronous host strobe (rising edge = one byte)
//   a_o, b_o, sel_o      registered operands/opcode to the ALU
//   alu_result, alu_cout ALU outputs
//   result_o, cout_o     captured ALU result and carry
//   valid_o              result_o/cout_o hold a completed operation
//   busy_o               high while in S_EXEC
//   overrun_o            sticky: a load arrived during S_EXEC
//   state_o              current state, for debug
// ----------------------------------------------------------------------------
module alu_operand_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       load_i,
    output logic [7:0] a_o,
    output logic [7:0] b_o,
    output logic [2:0] sel_o,
    input  logic [7:0] alu_result,
    input  logic       alu_cout,
    output logic [7:0] result_o,
    output logic       cout_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       overrun_o,
    output logic [2:0] state_o
);

    localparam int CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

    typedef enum logic [2:0] {
        S_A    = 3'b000,
        S_B    = 3'b001,
        S_OP   = 3'b010,
        S_EXEC = 3'b011,
        S_DONE = 3'b100
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   edge_q;
    logic                   load_pulse;
    logic [CNT_W-1:0]       cnt_q;
    logic [7:0]             a_q, b_q, result_q;
    logic [2:0]             sel_q;
    logic                   cout_q, valid_q, busy_q, overrun_q;

    // load_i shifts in at bit 0; the oldest sample sits in the MSB.
    assign sync_d     = {sync_q[SYNC_STAGES-2:0], load_i};
    assign load_pulse = sync_q[SYNC_STAGES-1] & ~edge_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_A;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                S_A: begin
                    if (load_pulse) begin
                        a_q     <= data_in;
                        state_q <= S_B;
                    end
                end
                S_B: begin
                    if (load_pulse) begin
                        b_q     <= data_in;
                        state_q <= S_OP;
                    end
                end
                S_OP: begin
                    if (load_pulse) begin
                        sel_q   <= data_in[2:0];
                        cnt_q   <= CNT_W'(ALU_LATENCY);
                        busy_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // A byte arriving now is dropped; operands stay frozen.
                    if (load_pulse) begin
                        overrun_q <= 1'b1;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= alu_result;
                        cout_q   <= alu_cout;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // The byte that ends S_DONE is already the next operand A.
                    if (load_pulse) begin
                        a_q     <= data_in;
                        valid_q <= 1'b0;
                        state_q <= S_B;
                    end
                end
                default: begin
                    state_q <= S_A;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign sel_o     = sel_q;
    assign result_o  = result_q;
    assign cout_o    = cout_q;
    assign valid_o   = valid_q;
    assign busy_o    = busy_q;
    assign overrun_o = overrun_q;
    assign state_o   = state_q;

endmodule
